// File: rtl/temporal_denoise_blend_pkg.sv
// Shared types and helpers for the temporal denoise blend datapath.
package temporal_denoise_blend_pkg;

   // Join state: SYNC waits for both streams to present a frame start, RUN streams pixels.
   typedef enum logic [0:0] {
      StSync = 1'b0,
      StRun  = 1'b1
   } state_e;

   // Beat width from channel layout; shared with the frame-buffer reader.
   function automatic int unsigned data_width(input int unsigned ch_width,
                                              input int unsigned num_ch);
      return ch_width * num_ch;
   endfunction

endpackage

// File: rtl/temporal_denoise_blend_lane.sv
// One colour channel: stage 1 does the motion test and both weighted products,
// stage 2 rounds, shifts and selects between the blend and the raw current pixel.
module temporal_denoise_blend_lane #(
   parameter int unsigned CH_WIDTH   = 8,
   parameter int unsigned ALPHA_BITS = 4
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  en,
   input  logic [CH_WIDTH-1:0]   prev_ch,
   input  logic [CH_WIDTH-1:0]   curr_ch,
   input  logic [ALPHA_BITS-1:0] alpha,
   input  logic [CH_WIDTH-1:0]   thresh,
   input  logic                  bypass,
   output logic [CH_WIDTH-1:0]   out_ch
);

   localparam int unsigned SUM_WIDTH = CH_WIDTH + ALPHA_BITS + 1;
   localparam int unsigned ROUND     = 1 << (ALPHA_BITS - 1);

   logic [CH_WIDTH:0]     diff;
   logic                  motion;
   logic [ALPHA_BITS:0]   w_curr;
   logic [SUM_WIDTH-1:0]  prod_c_q, prod_c_d, prod_p_q, prod_p_d, sum;
   logic [CH_WIDTH-1:0]   curr1_q, curr1_d, out_q, out_d;
   logic                  sel_q, sel_d;
   logic                  unused_sum_bits;

   // Stage 1: absolute difference, motion decision and the two weighted products.
   always_comb begin
      diff   = (curr_ch >= prev_ch) ? ({1'b0, curr_ch} - {1'b0, prev_ch})
                                    : ({1'b0, prev_ch} - {1'b0, curr_ch});
      motion = diff > {1'b0, thresh};
      // N - A spans 1..N, so it needs one bit more than alpha.
      w_curr = {1'b1, {ALPHA_BITS{1'b0}}} - {1'b0, alpha};
      prod_c_d = prod_c_q;
      prod_p_d = prod_p_q;
      curr1_d  = curr1_q;
      sel_d    = sel_q;
      if (en) begin
         prod_c_d = SUM_WIDTH'(curr_ch) * SUM_WIDTH'(w_curr);
         prod_p_d = SUM_WIDTH'(prev_ch) * SUM_WIDTH'(alpha);
         curr1_d  = curr_ch;
         sel_d    = bypass | motion;
      end
   end

   // Stage 2: round-to-nearest blend; the weighted sum never exceeds CH_WIDTH after the shift.
   always_comb begin
      sum   = prod_c_q + prod_p_q + SUM_WIDTH'(ROUND);
      out_d = out_q;
      if (en) begin
         out_d = sel_q ? curr1_q : sum[ALPHA_BITS +: CH_WIDTH];
      end
   end

   assign unused_sum_bits = ^{sum[SUM_WIDTH-1], sum[ALPHA_BITS-1:0]};

   // Pipeline registers for both stages.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         prod_c_q <= '0;
         prod_p_q <= '0;
         curr1_q  <= '0;
         sel_q    <= 1'b0;
         out_q    <= '0;
      end else begin
         prod_c_q <= prod_c_d;
         prod_p_q <= prod_p_d;
         curr1_q  <= curr1_d;
         sel_q    <= sel_d;
         out_q    <= out_d;
      end
   end

   assign out_ch = out_q;

endmodule

// File: rtl/temporal_denoise_blend.sv
// Motion-adaptive temporal denoise: joins previous- and current-frame AXIS streams,
// aligns them on frame start (tuser) and emits a per-channel weighted blend.
module temporal_denoise_blend
   import temporal_denoise_blend_pkg::*;
#(
   parameter  int unsigned CH_WIDTH   = 8,
   parameter  int unsigned NUM_CH     = 4,
   parameter  int unsigned ALPHA_BITS = 4,
   parameter  int unsigned CNT_WIDTH  = 16,
   localparam int unsigned DATA_WIDTH = data_width(CH_WIDTH, NUM_CH)
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_prev_axis_tdata,
   input  logic                  s_prev_axis_tvalid,
   input  logic                  s_prev_axis_tlast,
   input  logic                  s_prev_axis_tuser,
   output logic                  s_prev_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_curr_axis_tdata,
   input  logic                  s_curr_axis_tvalid,
   input  logic                  s_curr_axis_tlast,
   input  logic                  s_curr_axis_tuser,
   output logic                  s_curr_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   input  logic                  m_axis_tready,
   input  logic [ALPHA_BITS-1:0] cfg_alpha,
   input  logic [CH_WIDTH-1:0]   cfg_thresh,
   input  logic                  cfg_bypass,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic [CNT_WIDTH-1:0]  resync_cnt
);

   state_e                state_q, state_d;
   logic                  en, both_valid, mismatch, accept, cfg_load;
   logic                  prev_ready, curr_ready;
   logic [ALPHA_BITS-1:0] alpha_q, alpha_d;
   logic [CH_WIDTH-1:0]   thresh_q, thresh_d;
   logic                  bypass_q, bypass_d;
   logic                  v1_q, v1_d, last1_q, last1_d, user1_q, user1_d;
   logic                  v2_q, v2_d, last2_q, last2_d, user2_q, user2_d;
   logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d, resync_cnt_q, resync_cnt_d;
   logic                  unused_prev_tlast;

   // Join FSM: drop/hold in SYNC, lockstep accept in RUN, fall back to SYNC on tuser mismatch.
   always_comb begin
      en           = m_axis_tready | ~v2_q;
      both_valid   = s_prev_axis_tvalid & s_curr_axis_tvalid;
      mismatch     = both_valid & (s_prev_axis_tuser != s_curr_axis_tuser);
      state_d      = state_q;
      prev_ready   = 1'b0;
      curr_ready   = 1'b0;
      accept       = 1'b0;
      resync_cnt_d = resync_cnt_q;
      unique case (state_q)
         StSync: begin
            // Mid-frame beats are discarded; a frame start waits for its partner.
            prev_ready = s_prev_axis_tvalid & ~s_prev_axis_tuser;
            curr_ready = s_curr_axis_tvalid & ~s_curr_axis_tuser;
            if (both_valid & s_prev_axis_tuser & s_curr_axis_tuser & en) begin
               accept     = 1'b1;
               prev_ready = 1'b1;
               curr_ready = 1'b1;
               state_d    = StRun;
            end
         end
         StRun: begin
            if (mismatch) begin
               state_d = StSync;
               if (resync_cnt_q != '1) begin
                  resync_cnt_d = resync_cnt_q + CNT_WIDTH'(1);
               end
            end else begin
               prev_ready = s_curr_axis_tvalid & en;
               curr_ready = s_prev_axis_tvalid & en;
               accept     = both_valid & en;
            end
         end
         default: state_d = StSync;
      endcase
      if (!aresetn) begin
         prev_ready = 1'b0;
         curr_ready = 1'b0;
         accept     = 1'b0;
      end
   end

   // Config is captured on the frame-start beat and applies to that beat onward.
   always_comb begin
      cfg_load = accept & s_curr_axis_tuser;
      alpha_d  = cfg_load ? cfg_alpha  : alpha_q;
      thresh_d = cfg_load ? cfg_thresh : thresh_q;
      bypass_d = cfg_load ? cfg_bypass : bypass_q;
   end

   // Sideband pipe alongside the lanes, plus the output frame counter.
   always_comb begin
      v1_d    = v1_q;
      last1_d = last1_q;
      user1_d = user1_q;
      v2_d    = v2_q;
      last2_d = last2_q;
      user2_d = user2_q;
      if (en) begin
         v1_d    = accept;
         last1_d = accept & s_curr_axis_tlast;
         user1_d = accept & s_curr_axis_tuser;
         v2_d    = v1_q;
         last2_d = last1_q;
         user2_d = user1_q;
      end
      frame_cnt_d = frame_cnt_q;
      if (v2_q & m_axis_tready & user2_q) begin
         frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
      end
   end

   // Control, config and sideband state.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= StSync;
         alpha_q      <= '0;
         thresh_q     <= '0;
         bypass_q     <= 1'b0;
         v1_q         <= 1'b0;
         last1_q      <= 1'b0;
         user1_q      <= 1'b0;
         v2_q         <= 1'b0;
         last2_q      <= 1'b0;
         user2_q      <= 1'b0;
         frame_cnt_q  <= '0;
         resync_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         alpha_q      <= alpha_d;
         thresh_q     <= thresh_d;
         bypass_q     <= bypass_d;
         v1_q         <= v1_d;
         last1_q      <= last1_d;
         user1_q      <= user1_d;
         v2_q         <= v2_d;
         last2_q      <= last2_d;
         user2_q      <= user2_d;
         frame_cnt_q  <= frame_cnt_d;
         resync_cnt_q <= resync_cnt_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      temporal_denoise_blend_lane #(
         .CH_WIDTH   (CH_WIDTH),
         .ALPHA_BITS (ALPHA_BITS)
      ) u_lane (
         .aclk    (aclk),
         .aresetn (aresetn),
         .en      (en),
         .prev_ch (s_prev_axis_tdata[g*CH_WIDTH +: CH_WIDTH]),
         .curr_ch (s_curr_axis_tdata[g*CH_WIDTH +: CH_WIDTH]),
         .alpha   (alpha_d),
         .thresh  (thresh_d),
         .bypass  (bypass_d),
         .out_ch  (m_axis_tdata[g*CH_WIDTH +: CH_WIDTH])
      );
   end

   // Line boundaries follow the current frame; the previous frame's tlast carries nothing new.
   assign unused_prev_tlast  = s_prev_axis_tlast;

   assign s_prev_axis_tready = prev_ready;
   assign s_curr_axis_tready = curr_ready;
   assign m_axis_tvalid      = v2_q;
   assign m_axis_tlast       = last2_q;
   assign m_axis_tuser       = user2_q;
   assign frame_cnt          = frame_cnt_q;
   assign resync_cnt         = resync_cnt_q;

endmodule

// File: tb/tb_temporal_denoise_blend.sv
// Scoreboard bench: stimulus pushes beats into per-stream queues and the expected output
// into exp_q; the monitor pops and compares on every completed output beat.
module tb_temporal_denoise_blend;

   localparam int CW = 8;
   localparam int NC = 4;
   localparam int AB = 4;
   localparam int DW = CW * NC;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic          user;
   } beat_t;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [DW-1:0] s_prev_axis_tdata, s_curr_axis_tdata, m_axis_tdata;
   logic          s_prev_axis_tvalid, s_prev_axis_tlast, s_prev_axis_tuser, s_prev_axis_tready;
   logic          s_curr_axis_tvalid, s_curr_axis_tlast, s_curr_axis_tuser, s_curr_axis_tready;
   logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
   logic [AB-1:0] cfg_alpha = '0;
   logic [CW-1:0] cfg_thresh = '0;
   logic          cfg_bypass = 1'b0;
   logic [15:0]   frame_cnt, resync_cnt;

   beat_t prev_q[$];
   beat_t curr_q[$];
   beat_t exp_q[$];
   beat_t held, mon_e;
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    out_beats = 0;
   int    curr_pops = 0;
   int    user_fire_cyc = 0;
   int    user_out_cyc = 0;
   int    exp_frames = 0;
   bit    bp_en = 1'b0;
   bit    prev_fire, curr_fire;
   bit    stall_q = 1'b0;
   string phase = "reset";

   temporal_denoise_blend #(
      .CH_WIDTH   (CW),
      .NUM_CH     (NC),
      .ALPHA_BITS (AB),
      .CNT_WIDTH  (16)
   ) dut (
      .aclk               (aclk),
      .aresetn            (aresetn),
      .s_prev_axis_tdata  (s_prev_axis_tdata),
      .s_prev_axis_tvalid (s_prev_axis_tvalid),
      .s_prev_axis_tlast  (s_prev_axis_tlast),
      .s_prev_axis_tuser  (s_prev_axis_tuser),
      .s_prev_axis_tready (s_prev_axis_tready),
      .s_curr_axis_tdata  (s_curr_axis_tdata),
      .s_curr_axis_tvalid (s_curr_axis_tvalid),
      .s_curr_axis_tlast  (s_curr_axis_tlast),
      .s_curr_axis_tuser  (s_curr_axis_tuser),
      .s_curr_axis_tready (s_curr_axis_tready),
      .m_axis_tdata       (m_axis_tdata),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tlast       (m_axis_tlast),
      .m_axis_tuser       (m_axis_tuser),
      .m_axis_tready      (m_axis_tready),
      .cfg_alpha          (cfg_alpha),
      .cfg_thresh         (cfg_thresh),
      .cfg_bypass         (cfg_bypass),
      .frame_cnt          (frame_cnt),
      .resync_cnt         (resync_cnt)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
      end
   endtask

   // Reference blend per lane.
   function automatic logic [DW-1:0] ref_pix(input logic [DW-1:0] c, input logic [DW-1:0] p,
                                             input int a, input int t, input bit byp);
      logic [DW-1:0] o;
      int ci, pi, d;
      o = '0;
      for (int l = 0; l < NC; l++) begin
         ci = int'(c[l*CW +: CW]);
         pi = int'(p[l*CW +: CW]);
         d  = (ci > pi) ? ci - pi : pi - ci;
         if (byp || d > t) o[l*CW +: CW] = 8'(ci);
         else o[l*CW +: CW] = 8'((ci * ((1 << AB) - a) + pi * a + (1 << (AB - 1))) >> AB);
      end
      return o;
   endfunction

   task automatic push_prev(input logic [DW-1:0] d, input bit last, input bit user);
      prev_q.push_back('{data: d, last: last, user: user});
   endtask

   task automatic push_curr(input logic [DW-1:0] d, input bit last, input bit user);
      curr_q.push_back('{data: d, last: last, user: user});
   endtask

   task automatic push_exp(input logic [DW-1:0] d, input bit last, input bit user);
      exp_q.push_back('{data: d, last: last, user: user});
      if (user) exp_frames++;
   endtask

   task automatic push_pair(input logic [DW-1:0] c, input logic [DW-1:0] p, input bit last,
                            input bit user, input int a, input int t, input bit byp);
      push_curr(c, last, user);
      push_prev(p, last, user);
      push_exp(ref_pix(c, p, a, t, byp), last, user);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge aclk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d beats still outstanding, want 0", name, exp_q.size());
      end
      repeat (4) @(posedge aclk);
      #2;
   endtask

   task automatic pulse_reset();
      @(posedge aclk);
      #2;
      aresetn = 1'b0;
      prev_q.delete();
      curr_q.delete();
      exp_q.delete();
      exp_frames = 0;
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
   endtask

   // Previous-frame stream driver.
   initial begin
      s_prev_axis_tvalid = 1'b0;
      s_prev_axis_tdata  = '0;
      s_prev_axis_tlast  = 1'b0;
      s_prev_axis_tuser  = 1'b0;
      forever begin
         @(negedge aclk);
         prev_fire = s_prev_axis_tvalid && s_prev_axis_tready;
         @(posedge aclk);
         #1;
         if (prev_fire && prev_q.size() > 0) void'(prev_q.pop_front());
         s_prev_axis_tvalid = prev_q.size() > 0;
         if (prev_q.size() > 0) begin
            s_prev_axis_tdata = prev_q[0].data;
            s_prev_axis_tlast = prev_q[0].last;
            s_prev_axis_tuser = prev_q[0].user;
         end
      end
   end

   // Current-frame stream driver; also notes when a frame start is accepted.
   initial begin
      s_curr_axis_tvalid = 1'b0;
      s_curr_axis_tdata  = '0;
      s_curr_axis_tlast  = 1'b0;
      s_curr_axis_tuser  = 1'b0;
      forever begin
         @(negedge aclk);
         curr_fire = s_curr_axis_tvalid && s_curr_axis_tready;
         if (curr_fire && s_curr_axis_tuser && s_prev_axis_tready) user_fire_cyc = cyc;
         @(posedge aclk);
         #1;
         if (curr_fire && curr_q.size() > 0) begin
            void'(curr_q.pop_front());
            curr_pops++;
         end
         s_curr_axis_tvalid = curr_q.size() > 0;
         if (curr_q.size() > 0) begin
            s_curr_axis_tdata = curr_q[0].data;
            s_curr_axis_tlast = curr_q[0].last;
            s_curr_axis_tuser = curr_q[0].user;
         end
      end
   end

   // Output backpressure.
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         m_axis_tready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
      end
   end

   // Monitor: compares completed beats against the scoreboard and checks stall stability.
   initial begin
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            stall_q = 1'b0;
         end else begin
            if (stall_q && m_axis_tvalid) begin
               checks++;
               if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== held) begin
                  errors++;
                  $display("FAIL %s_stall_hold: got 0x%0h/%0b/%0b want 0x%0h/%0b/%0b", phase,
                           m_axis_tdata, m_axis_tlast, m_axis_tuser,
                           held.data, held.last, held.user);
               end
            end
            if (m_axis_tvalid && m_axis_tready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL %s_extra_beat: got 0x%0h want no beat", phase, m_axis_tdata);
               end else begin
                  mon_e = exp_q.pop_front();
                  out_beats++;
                  if (m_axis_tuser) user_out_cyc = cyc;
                  if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== mon_e) begin
                     errors++;
                     $display("FAIL %s_beat: got 0x%0h/%0b/%0b want 0x%0h/%0b/%0b", phase,
                              m_axis_tdata, m_axis_tlast, m_axis_tuser,
                              mon_e.data, mon_e.last, mon_e.user);
                  end
               end
            end
            stall_q = m_axis_tvalid && !m_axis_tready;
            held    = '{data: m_axis_tdata, last: m_axis_tlast, user: m_axis_tuser};
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] c, p;
      int base, n;

      // Reset: a pending mid-frame prev beat must not be dropped while reset is held.
      push_prev(32'h11111111, 1'b0, 1'b0);
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_prev_tready", s_prev_axis_tready, 0);
      check("rst_curr_tready", s_curr_axis_tready, 0);
      check("rst_m_tvalid", m_axis_tvalid, 0);
      check("rst_m_tdata", m_axis_tdata, 0);
      check("rst_m_tlast_tuser", {m_axis_tlast, m_axis_tuser}, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_resync_cnt", resync_cnt, 0);
      prev_q.delete();
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      #2;

      // Blend: 100 vs 200 at alpha 8 -> 150; one beat with mixed lanes.
      phase      = "blend";
      cfg_alpha  = 4'd8;
      cfg_thresh = 8'd255;
      cfg_bypass = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            push_curr(32'h00FF3264, 1'b0, 1'b0);
            push_prev(32'h00FF32C8, 1'b0, 1'b0);
            push_exp(32'h00FF3296, 1'b0, 1'b0);
         end else begin
            push_curr(32'h64646464, i == 3, i == 0);
            push_prev(32'hC8C8C8C8, i == 3, i == 0);
            push_exp(32'h96969696, i == 3, i == 0);
         end
      end
      wait_drain("blend", 200);
      check("blend_latency", user_out_cyc - user_fire_cyc, 2);
      check("blend_frame_cnt", frame_cnt, exp_frames);

      // Motion: thresh 50 passes curr through; a mid-frame change waits for the next frame.
      phase      = "motion";
      cfg_alpha  = 4'd15;
      cfg_thresh = 8'd50;
      base       = curr_pops;
      for (int i = 0; i < 4; i++) begin
         push_curr(32'h0A0A0A0A, i == 3, i == 0);
         push_prev(32'hC8C8C8C8, i == 3, i == 0);
         push_exp(32'h0A0A0A0A, i == 3, i == 0);
      end
      n = 0;
      while (curr_pops == base && n < 50) begin
         @(posedge aclk);
         #2;
         n++;
      end
      check("motion_first_accept", curr_pops > base, 1);
      cfg_thresh = 8'd200;
      for (int i = 0; i < 4; i++) begin
         push_curr(32'h0A0A0A0A, i == 3, i == 0);
         push_prev(32'hC8C8C8C8, i == 3, i == 0);
         push_exp(32'hBCBCBCBC, i == 3, i == 0);
      end
      wait_drain("motion", 200);
      check("motion_frame_cnt", frame_cnt, exp_frames);

      // Bypass: curr passes through bit-exact with its sideband.
      phase      = "bypass";
      cfg_bypass = 1'b1;
      cfg_alpha  = 4'd3;
      cfg_thresh = 8'd0;
      for (int i = 0; i < 8; i++) begin
         c = $urandom;
         p = $urandom;
         push_curr(c, (i == 7) || ($urandom_range(0, 3) == 0), i == 0);
         push_prev(p, 1'b0, i == 0);
         push_exp(c, curr_q[curr_q.size()-1].last, i == 0);
      end
      wait_drain("bypass", 200);
      check("bypass_frame_cnt", frame_cnt, exp_frames);

      // Backpressure: 64x4 frame under 30% output stalls.
      phase      = "backpressure";
      cfg_bypass = 1'b0;
      cfg_alpha  = 4'd5;
      cfg_thresh = 8'd40;
      bp_en      = 1'b1;
      base       = out_beats;
      for (int i = 0; i < 256; i++) begin
         c = $urandom;
         p = c ^ ($urandom & (($urandom_range(0, 1) == 0) ? 32'h1F1F1F1F : 32'hFFFFFFFF));
         push_pair(c, p, (i % 64) == 63, i == 0, 5, 40, 1'b0);
      end
      wait_drain("backpressure", 4000);
      bp_en = 1'b0;
      check("bp_beat_count", out_beats - base, 256);
      check("bp_frame_cnt", frame_cnt, exp_frames);

      // Resync: prev leads with three mid-frame beats, then curr restarts mid-frame in RUN.
      phase = "resync";
      pulse_reset();
      cfg_alpha  = 4'd8;
      cfg_thresh = 8'd255;
      for (int i = 0; i < 3; i++) push_prev(32'h01020304 + i, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) push_pair($urandom, $urandom, i == 3, i == 0, 8, 255, 1'b0);
      wait_drain("resync_a", 200);
      check("resync_a_cnt", resync_cnt, 0);
      check("resync_a_frames", frame_cnt, 1);
      push_pair($urandom, $urandom, 1'b0, 1'b1, 8, 255, 1'b0);
      push_pair($urandom, $urandom, 1'b0, 1'b0, 8, 255, 1'b0);
      for (int i = 0; i < 4; i++) push_prev($urandom, i == 3, 1'b0);
      for (int i = 0; i < 4; i++) push_pair($urandom, $urandom, i == 3, i == 0, 8, 255, 1'b0);
      wait_drain("resync_b", 200);
      check("resync_b_cnt", resync_cnt, 1);
      check("resync_b_frames", frame_cnt, 3);
      check("resync_b_prev_consumed", prev_q.size(), 0);

      // Reset mid-frame: pipe discarded, counters cleared, next frame processed from scratch.
      phase = "midreset";
      for (int i = 0; i < 8; i++) push_pair($urandom, $urandom, i == 7, i == 0, 8, 255, 1'b0);
      base = out_beats;
      n    = 0;
      while (out_beats < base + 2 && n < 100) begin
         @(posedge aclk);
         n++;
      end
      check("midreset_started", out_beats >= base + 2, 1);
      pulse_reset();
      @(negedge aclk);
      check("midreset_m_tvalid", m_axis_tvalid, 0);
      check("midreset_m_tdata", m_axis_tdata, 0);
      check("midreset_m_side", {m_axis_tlast, m_axis_tuser}, 0);
      check("midreset_frame_cnt", frame_cnt, 0);
      check("midreset_resync_cnt", resync_cnt, 0);
      @(posedge aclk);
      #2;
      for (int i = 0; i < 4; i++) push_pair($urandom, $urandom, i == 3, i == 0, 8, 255, 1'b0);
      wait_drain("midreset", 200);
      check("midreset_next_frame_cnt", frame_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
